// File: rtl/room_renderer.sv
// rtl/room_renderer.sv - room background generator with four sliding doorways
// One-cycle pixel classification (black / wall / floor) driven by per-door half-width state.
module room_renderer #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          WALL_T    = 40,
    parameter int          DOOR_HALF = 60,
    parameter int          STEP      = 4,
    parameter logic [7:0]  FLOOR     = 8'hFE
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic [9:0]  CurrentX,
    input  logic [8:0]  CurrentY,
    input  logic [7:0]  wall,
    input  logic        frame_tick,
    input  logic [3:0]  door_req,
    output logic [7:0]  mapData,
    output logic [3:0]  door_open,
    output logic [3:0]  door_moving
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } doorState_t;

    localparam int DN = 0;
    localparam int DE = 1;
    localparam int DS = 2;
    localparam int DW = 3;

    localparam logic [11:0] CX     = 12'(H_RES / 2);
    localparam logic [11:0] CY     = 12'(V_RES / 2);
    localparam logic [11:0] WALLW  = 12'(WALL_T);
    localparam logic [11:0] XRIGHT = 12'(H_RES - WALL_T);
    localparam logic [11:0] YBOT   = 12'(V_RES - WALL_T);
    localparam logic [10:0] HMAX   = 11'(DOOR_HALF);
    localparam logic [10:0] HSTEP  = 11'(STEP);

    doorState_t doorState     [4];
    doorState_t doorStateNext [4];
    logic [9:0] halfW         [4];
    logic [9:0] halfWNext     [4];
    logic [9:0] halfUp        [4];
    logic [9:0] halfDown      [4];
    logic [3:0] openNext;
    logic [3:0] movingNext;
    logic [7:0] pixNext;

    always_comb begin
        openNext   = 4'b0000;
        movingNext = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            doorStateNext[i] = doorState[i];
            halfWNext[i]     = halfW[i];
            // Saturating step in 11 bits so neither direction can wrap.
            if (({1'b0, halfW[i]} + HSTEP) >= HMAX)
                halfUp[i] = HMAX[9:0];
            else
                halfUp[i] = halfW[i] + HSTEP[9:0];
            if ({1'b0, halfW[i]} <= HSTEP)
                halfDown[i] = 10'd0;
            else
                halfDown[i] = halfW[i] - HSTEP[9:0];

            if (frame_tick) begin
                case (doorState[i])
                    CLOSED: begin
                        if (door_req[i]) begin
                            doorStateNext[i] = OPENING;
                            halfWNext[i]     = halfUp[i];
                        end
                    end
                    OPENING: begin
                        if (door_req[i]) begin
                            halfWNext[i]     = halfUp[i];
                            doorStateNext[i] = (halfUp[i] == HMAX[9:0]) ? OPEN : OPENING;
                        end else begin
                            halfWNext[i]     = halfDown[i];
                            doorStateNext[i] = (halfDown[i] == 10'd0) ? CLOSED : CLOSING;
                        end
                    end
                    OPEN: begin
                        if (!door_req[i]) begin
                            doorStateNext[i] = CLOSING;
                            halfWNext[i]     = halfDown[i];
                        end
                    end
                    CLOSING: begin
                        if (door_req[i]) begin
                            doorStateNext[i] = OPENING;
                            halfWNext[i]     = halfUp[i];
                        end else begin
                            halfWNext[i]     = halfDown[i];
                            doorStateNext[i] = (halfDown[i] == 10'd0) ? CLOSED : CLOSING;
                        end
                    end
                    default: begin
                        doorStateNext[i] = CLOSED;
                        halfWNext[i]     = 10'd0;
                    end
                endcase
            end
            openNext[i]   = (doorStateNext[i] == OPEN);
            movingNext[i] = (doorStateNext[i] == OPENING) || (doorStateNext[i] == CLOSING);
        end
    end

    // Window test written as pos+h >= c so the lower bound never underflows.
    function automatic logic inWindow(input logic [11:0] pos, input logic [11:0] c,
                                      input logic [9:0] h);
        logic [11:0] hw;
        hw = {2'b00, h};
        return ((pos + hw) >= c) && (pos < (c + hw));
    endfunction

    logic [11:0] px;
    logic [11:0] py;
    assign px = {2'b00, CurrentX};
    assign py = {3'b000, CurrentY};

    always_comb begin
        pixNext = FLOOR;
        if (px >= 12'(H_RES) || py >= 12'(V_RES))
            pixNext = 8'h00;
        else if (py < WALLW && inWindow(px, CX, halfW[DN]))
            pixNext = FLOOR;
        else if (py >= YBOT && inWindow(px, CX, halfW[DS]))
            pixNext = FLOOR;
        else if (px < WALLW && inWindow(py, CY, halfW[DW]))
            pixNext = FLOOR;
        else if (px >= XRIGHT && inWindow(py, CY, halfW[DE]))
            pixNext = FLOOR;
        else if (px < WALLW || px >= XRIGHT || py < WALLW || py >= YBOT)
            pixNext = wall;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                doorState[i] <= CLOSED;
                halfW[i]     <= 10'd0;
            end
            door_open   <= 4'b0000;
            door_moving <= 4'b0000;
            mapData     <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                doorState[i] <= doorStateNext[i];
                halfW[i]     <= halfWNext[i];
            end
            door_open   <= openNext;
            door_moving <= movingNext;
            mapData     <= pixNext;
        end
    end

endmodule

// File: tb/tb_room_renderer.sv
// tb/tb_room_renderer.sv - directed scoreboard bench for room_renderer
// Expected pixel colours are queued when coordinates are driven and popped one edge later.
module tb_room_renderer;

    localparam logic [7:0] FLOORC = 8'hFE;

    logic       clk_vga = 1'b0;
    logic       rst;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic [7:0] wall;
    logic       frame_tick;
    logic [3:0] door_req;
    logic [7:0] mapData;
    logic [3:0] door_open;
    logic [3:0] door_moving;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ [$];
    string      tagQ [$];

    always #5 clk_vga = ~clk_vga;

    room_renderer dut (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .CurrentX    (CurrentX),
        .CurrentY    (CurrentY),
        .wall        (wall),
        .frame_tick  (frame_tick),
        .door_req    (door_req),
        .mapData     (mapData),
        .door_open   (door_open),
        .door_moving (door_moving)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic popCheck();
        string      t;
        logic [7:0] e;
        t = tagQ.pop_front();
        e = expQ.pop_front();
        check(t, mapData, e);
    endtask

    // Drive one coordinate (optionally with a tick on the same edge) and score it.
    task automatic drivePix(input int x, input int y, input logic [7:0] e,
                            input string tag, input logic withTick);
        @(negedge clk_vga);
        CurrentX   = 10'(x);
        CurrentY   = 9'(y);
        frame_tick = withTick;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk_vga);
        #1;
        frame_tick = 1'b0;
        popCheck();
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] e, input string tag);
        drivePix(x, y, e, tag, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk_vga);
        frame_tick = 1'b1;
        @(posedge clk_vga);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk_vga);
        rst = 1'b1;
        @(posedge clk_vga);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkDoors(input string tag, input logic [3:0] expOpen,
                              input logic [3:0] expMoving);
        check({tag, "_open"}, {4'h0, door_open}, {4'h0, expOpen});
        check({tag, "_moving"}, {4'h0, door_moving}, {4'h0, expMoving});
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        door_req   = 4'b0000;
        CurrentX   = 10'd320;
        CurrentY   = 9'd240;
        wall       = 8'h5A;
        repeat (2) @(posedge clk_vga);
        #1;
        check("reset_mapData", mapData, 8'h00);
        checkDoors("reset", 4'b0000, 4'b0000);
        @(negedge clk_vga);
        rst = 1'b0;

        pix(0, 0, 8'h5A, "scan_0_0");
        pix(320, 20, 8'h5A, "scan_320_20");
        pix(20, 240, 8'h5A, "scan_20_240");
        pix(320, 240, FLOORC, "scan_320_240");
        wall = 8'hA5;
        pix(639, 479, 8'hA5, "scan_639_479");
        pix(700, 100, 8'h00, "scan_700_100");
        pix(100, 500, 8'h00, "scan_100_500");
        wall = 8'h5A;

        // North door opens; the pixel sampled on the tick edge still sees h=0.
        door_req = 4'b0001;
        drivePix(318, 10, 8'h5A, "tick_edge_old_geom", 1'b1);
        checkDoors("n_tick1", 4'b0000, 4'b0001);
        pix(318, 10, FLOORC, "n_h4_inside");
        pix(315, 10, 8'h5A, "n_h4_outside");
        for (int k = 2; k <= 15; k++) begin
            tick();
            checkDoors($sformatf("n_tick%0d", k), (k == 15) ? 4'b0001 : 4'b0000,
                       (k == 15) ? 4'b0000 : 4'b0001);
        end
        pix(260, 10, FLOORC, "n_open_260");
        pix(379, 10, FLOORC, "n_open_379");
        pix(259, 10, 8'h5A, "n_open_259");
        pix(380, 10, 8'h5A, "n_open_380");
        pix(320, 470, 8'h5A, "s_still_closed");

        // Reverse mid-travel.
        doReset();
        checkDoors("rst_before_rev", 4'b0000, 4'b0000);
        door_req = 4'b0001;
        repeat (5) tick();
        pix(300, 10, FLOORC, "n_h20_300");
        pix(299, 10, 8'h5A, "n_h20_299");
        door_req = 4'b0000;
        tick();
        checkDoors("n_closing", 4'b0000, 4'b0001);
        pix(304, 10, FLOORC, "n_h16_304");
        pix(303, 10, 8'h5A, "n_h16_303");
        pix(335, 10, FLOORC, "n_h16_335");
        pix(336, 10, 8'h5A, "n_h16_336");
        door_req = 4'b0001;
        tick();
        checkDoors("n_reopening", 4'b0000, 4'b0001);
        pix(300, 10, FLOORC, "n_h20b_300");
        pix(299, 10, 8'h5A, "n_h20b_299");

        // All four doors fully open.
        doReset();
        door_req = 4'hF;
        repeat (15) tick();
        checkDoors("all_open", 4'hF, 4'h0);
        pix(20, 180, FLOORC, "w_20_180");
        pix(20, 179, 8'h5A, "w_20_179");
        pix(20, 299, FLOORC, "w_20_299");
        pix(20, 300, 8'h5A, "w_20_300");
        pix(620, 180, FLOORC, "e_620_180");
        pix(620, 300, 8'h5A, "e_620_300");
        pix(260, 470, FLOORC, "s_260_470");
        pix(259, 470, 8'h5A, "s_259_470");
        pix(0, 0, 8'h5A, "corner_0_0");
        pix(639, 0, 8'h5A, "corner_639_0");

        // No tick means no movement.
        doReset();
        door_req = 4'hF;
        repeat (1000) @(posedge clk_vga);
        #1;
        checkDoors("hold_1000", 4'h0, 4'h0);
        pix(320, 10, 8'h5A, "hold_n_closed");

        // Reset wins over a coincident tick.
        @(negedge clk_vga);
        rst        = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk_vga);
        #1;
        frame_tick = 1'b0;
        rst        = 1'b0;
        checkDoors("rst_tick", 4'h0, 4'h0);
        pix(320, 10, 8'h5A, "rst_tick_n_closed");

        // Reset in the middle of an opening animation.
        door_req = 4'hF;
        repeat (3) tick();
        checkDoors("mid_open", 4'h0, 4'hF);
        pix(320, 10, FLOORC, "mid_open_floor");
        doReset();
        checkDoors("mid_rst", 4'h0, 4'h0);
        pix(320, 10, 8'h5A, "mid_rst_n_closed");
        pix(20, 240, 8'h5A, "mid_rst_w_closed");

        check("scoreboard_empty", 8'(expQ.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/room_renderer.md
# room_renderer

Parametrised room background generator for the VGA path. For every pixel coordinate it returns an 8-bit colour: wall, floor or black, with one cycle of latency. Each of the four walls has a centred doorway that slides open or closed over several frames. It replaces the fixed single-layout hallway generators, and its output feeds the sprite/overlay mux exactly as `mapData` did.

## Interface
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `WALL_T`, 40: wall thickness in pixels, the same on all four sides.
- `DOOR_HALF`, 60: half-width of a fully open doorway.
  - Constraint: `DOOR_HALF` ≤ `V_RES`/2 − `WALL_T`, so corners are always wall.
- `STEP`, 4: pixels of half-width gained or lost per frame tick while a door moves.
- `FLOOR`, 8'hFE: floor colour.

- `clk_vga` input 1: pixel clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `CurrentX` input 10: pixel column.
- `CurrentY` input 9: pixel row.
- `wall` input 8: wall colour, sampled every cycle.
- `frame_tick` input 1: one-cycle pulse once per frame, during blanking.
- `door_req` input 4: requested door state, bit0 N, bit1 E, bit2 S, bit3 W; 1 = open.
- `mapData` output 8: registered pixel colour.
- `door_open` output 4: door fully open (state OPEN), per door.
- `door_moving` output 4: door in OPENING or CLOSING, per door.

## Operation
- Each door keeps a state (CLOSED, OPENING, OPEN, CLOSING) and a half-width `h` (10 bits, 0..`DOOR_HALF`).
- Door state changes only on cycles where `frame_tick` = 1. With `frame_tick` = 0, state and `h` hold.
- Transitions on a tick, with `r` = the door's `door_req` bit:
  - CLOSED, r=1 → OPENING, `h` += `STEP`.
  - OPENING, r=1: `h` = min(`h`+`STEP`, `DOOR_HALF`). If the result equals `DOOR_HALF` → OPEN.
  - OPENING, r=0 → CLOSING, `h` = max(`h`−`STEP`, 0). If the result is 0 → CLOSED.
  - OPEN, r=0 → CLOSING, `h` −= `STEP`.
  - CLOSING, r=0: `h` = max(`h`−`STEP`, 0). If the result is 0 → CLOSED.
  - CLOSING, r=1 → OPENING, `h` += `STEP` with saturation.
  - CLOSED with r=0, and OPEN with r=1: no change.
- A `STEP` that does not divide `DOOR_HALF` saturates the last step. `h` never leaves 0..`DOOR_HALF`.
- Pixel classification, in priority order (`CX` = `H_RES`/2, `CY` = `V_RES`/2):
  1. `CurrentX` ≥ `H_RES` or `CurrentY` ≥ `V_RES` → 8'h00.
  2. N gap: `CurrentY` < `WALL_T` and `CX`−`h_N` ≤ `CurrentX` < `CX`+`h_N` → `FLOOR`.
  3. S gap: `CurrentY` ≥ `V_RES`−`WALL_T`, same X window using `h_S` → `FLOOR`.
  4. W gap: `CurrentX` < `WALL_T` and `CY`−`h_W` ≤ `CurrentY` < `CY`+`h_W` → `FLOOR`.
  5. E gap: `CurrentX` ≥ `H_RES`−`WALL_T`, same Y window using `h_E` → `FLOOR`.
  6. Within `WALL_T` of any edge → `wall`.
  7. Otherwise → `FLOOR`.
- `h` = 0 gives an empty window, so the wall is solid.
- Compare in at least 11 bits so `CX`−`h` never wraps.

## Timing
- `mapData` latency is 1 cycle: coordinates and `wall` sampled at edge n produce the colour after edge n.
- Classification uses the `h` values registered before edge n.
  - A tick at edge n changes the geometry from the pixel sampled at edge n+1 onward.
- `door_open` and `door_moving` are registered and update on the same edge as the state.
- Reset values:
  - `mapData` = 8'h00.
  - All doors CLOSED, `h` = 0.
  - `door_open` = 4'b0000, `door_moving` = 4'b0000.
- `rst` has priority over `frame_tick`. Reset mid-animation returns the door to CLOSED, `h` = 0, on the next edge.
- The four doors are independent. Any combination of doors may change on the same tick.

## Test plan
- Reset, then scan (0,0), (320,20), (20,240), (320,240), (639,479), (700,100):
  - Expect `wall`, `wall`, `wall`, `FLOOR`, `wall`, 8'h00.
  - Each value appears one cycle after its coordinate.
- Set `door_req` = 4'b0001 and pulse `frame_tick` 15 times:
  - `h_N` goes 4, 8, …, 60.
  - `door_moving`[0] = 1 until the 15th tick, then `door_open`[0] = 1.
  - (260,10) and (379,10) give `FLOOR`; (259,10) and (380,10) give `wall`.
- Open N to `h` = 20 (5 ticks), clear the request, then tick:
  - Expect CLOSING with `h` = 16.
  - Set the request again and tick: expect OPENING with `h` = 20.
- Set all doors open and tick 15 times:
  - Expect `door_open` = 4'hF.
  - (20,180) gives `FLOOR`, (20,179) gives `wall`, (0,0) gives `wall`.
- Hold `frame_tick` = 0 with `door_req` = 4'hF for 1000 cycles: no state change.
- Pulse `frame_tick` in the same cycle as `rst`: all doors stay CLOSED.
- Reset mid-open: `h` = 0 and `door_moving` = 0 on the next edge.
